// File: rtl/periph_rx_scheduler_pkg.sv
// Shared types and constants for the peripheral RX scheduler.
package periph_rx_scheduler_pkg;

    localparam int unsigned num_peripherals = 8;
    localparam int unsigned sched_burst_max = 16;
    localparam int unsigned burst_cnt_w     = 8;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} sched_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request strictly after ptr, ascending with wrap.
module rr_priority_picker #(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    logic [2*N-1:0] dbl;

    // Lowest set bit of the doubled vector inside the window (ptr, ptr+N].
    always_comb begin
        dbl     = {req_i, req_i};
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (dbl[i] && (i > int'(ptr_i)) && (i <= int'(ptr_i) + int'(N))) begin
                found_o = 1'b1;
                idx_o   = W'(i);
            end
        end
    end

endmodule

// File: rtl/periph_rx_scheduler.sv
// Burst-aware round-robin scheduler sharing the upstream FIFO write port
// among peripheral RX FIFOs; urgent (almost-full) peripherals win arbitration.
module periph_rx_scheduler
    import periph_rx_scheduler_pkg::*;
#(
    parameter int unsigned NUM_PERIPHS = num_peripherals,
    parameter int unsigned BURST_MAX   = sched_burst_max,
    parameter int unsigned GRANT_W     = $clog2(NUM_PERIPHS)
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   en,
    input  logic [NUM_PERIPHS-1:0] rx_empty,
    input  logic [NUM_PERIPHS-1:0] rx_almost_full,
    input  logic                   out_full,
    output logic [GRANT_W-1:0]     grant,
    output logic                   grant_valid,
    output logic [NUM_PERIPHS-1:0] rx_rden,
    output logic [7:0]             burst_cnt,
    output logic                   idle
);

    localparam logic [burst_cnt_w-1:0] burst_max_v  = burst_cnt_w'(BURST_MAX);
    localparam logic [burst_cnt_w-1:0] burst_last_v = burst_cnt_w'(BURST_MAX - 1);

    sched_state_t             state_q, state_d;
    logic [GRANT_W-1:0]       grant_q, grant_d;
    logic [GRANT_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                     grant_valid_q, grant_valid_d;
    logic [burst_cnt_w-1:0]   burst_cnt_q, burst_cnt_d;

    logic [NUM_PERIPHS-1:0]   req, urg, others_urg;
    logic                     urg_found, all_found;
    logic [GRANT_W-1:0]       urg_idx, all_idx;
    logic                     strobe;

    assign req = ~rx_empty;
    assign urg = req & rx_almost_full;

    rr_priority_picker #(.N(NUM_PERIPHS), .W(GRANT_W)) u_pick_urg (
        .req_i   (urg),
        .ptr_i   (rr_ptr_q),
        .found_o (urg_found),
        .idx_o   (urg_idx)
    );

    rr_priority_picker #(.N(NUM_PERIPHS), .W(GRANT_W)) u_pick_all (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .found_o (all_found),
        .idx_o   (all_idx)
    );

    // Next-state, counter and pointer update.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        burst_cnt_d   = burst_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        strobe        = 1'b0;
        others_urg    = urg & ~(NUM_PERIPHS'(1) << grant_q);

        case (state_q)
            IDLE: begin
                if (en && all_found) begin
                    grant_d       = urg_found ? urg_idx : all_idx;
                    grant_valid_d = 1'b1;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                strobe = req[grant_q] & ~out_full;
                if (strobe && (burst_cnt_q < burst_max_v)) begin
                    burst_cnt_d = burst_cnt_q + burst_cnt_w'(1);
                end
                // out_full alone holds the grant; everything else below ends the burst.
                if ((strobe && (burst_cnt_q == burst_last_v)) ||
                    !req[grant_q] || !en ||
                    (!urg[grant_q] && (|others_urg) && (burst_cnt_q != '0))) begin
                    state_d       = RELEASE;
                    grant_valid_d = 1'b0;
                end
            end
            RELEASE: begin
                rr_ptr_d    = grant_q;
                burst_cnt_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            burst_cnt_q   <= '0;
            rr_ptr_q      <= GRANT_W'(NUM_PERIPHS - 1);
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            burst_cnt_q   <= burst_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign burst_cnt   = burst_cnt_q;
    assign rx_rden     = strobe ? (NUM_PERIPHS'(1) << grant_q) : '0;
    assign idle        = (state_q == IDLE) && !(|req);

endmodule

// File: tb/tb_periph_rx_scheduler.sv
// Scoreboard bench for periph_rx_scheduler: emulated peripheral FIFOs,
// transaction-level reference model and a decoupled output monitor.
module tb_periph_rx_scheduler;

    localparam int N  = 8;
    localparam int BM = 4;
    localparam int GW = 3;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          en;
    logic [N-1:0]  rx_empty;
    logic [N-1:0]  rx_almost_full;
    logic          out_full;
    logic [GW-1:0] grant;
    logic          grant_valid;
    logic [N-1:0]  rx_rden;
    logic [7:0]    burst_cnt;
    logic          idle;

    periph_rx_scheduler #(.NUM_PERIPHS(N), .BURST_MAX(BM)) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .en             (en),
        .rx_empty       (rx_empty),
        .rx_almost_full (rx_almost_full),
        .out_full       (out_full),
        .grant          (grant),
        .grant_valid    (grant_valid),
        .rx_rden        (rx_rden),
        .burst_cnt      (burst_cnt),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    int cnt [N];
    always_comb begin
        for (int i = 0; i < N; i++) rx_empty[i] = (cnt[i] == 0);
    end

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct { int idx; int bc; } strobe_t;
    typedef struct { bit gv; int grant; int bc; bit idl; bit rst; } stat_t;
    strobe_t sq [$];
    stat_t   tq [$];
    int      gseq [$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input bit [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Reference model: owner of the port, words taken, bubble after a burst.
    int m_owner  = -1;
    int m_taken  = 0;
    int m_last   = N - 1;
    bit m_bubble = 1'b0;

    always @(negedge clk) begin : model
        bit [N-1:0] r, u, oh;
        stat_t      s;
        strobe_t    e;
        bit         strb, fin;
        for (int i = 0; i < N; i++) r[i] = (cnt[i] > 0);
        u = r & rx_almost_full;
        s.gv = 1'b0; s.grant = 0; s.bc = 0; s.idl = 1'b0; s.rst = 1'b0;
        if (!rst_l) begin
            m_owner = -1; m_taken = 0; m_last = N - 1; m_bubble = 1'b0;
            s.rst = 1'b1;
            s.idl = (r == '0);
        end else if (m_bubble) begin
            s.bc     = m_taken;
            m_bubble = 1'b0;
            m_owner  = -1;
            m_taken  = 0;
        end else if (m_owner < 0) begin
            s.idl = (r == '0);
            if (en && r != '0) m_owner = rr_pick((u != '0) ? u : r, m_last);
        end else begin
            s.gv    = 1'b1;
            s.grant = m_owner;
            s.bc    = m_taken;
            oh      = N'(1) << m_owner;
            strb    = r[m_owner] && !out_full;
            if (strb) begin
                e.idx = m_owner;
                e.bc  = m_taken;
                sq.push_back(e);
            end
            fin = (strb && m_taken == BM - 1) || !r[m_owner] || !en ||
                  (!u[m_owner] && ((u & ~oh) != '0) && m_taken >= 1);
            if (strb && m_taken < BM) m_taken++;
            if (fin) begin
                m_bubble = 1'b1;
                m_last   = m_owner;
            end
        end
        tq.push_back(s);
    end

    // Monitor: invariants, per-cycle status and strobe scoreboard.
    bit prev_gv = 1'b0;
    always @(negedge clk) begin : monitor
        stat_t   s;
        strobe_t e;
        int      ridx;
        #1;
        n_cmp++;
        if (!$onehot0(rx_rden) || ((rx_rden & (rx_empty | {N{out_full}})) != '0) ||
            (int'(burst_cnt) > BM)) begin
            n_fail++;
            $display("FAIL invariant: rx_rden=%b rx_empty=%b out_full=%b burst_cnt=%0d",
                     rx_rden, rx_empty, out_full, burst_cnt);
        end
        if (tq.size() == 0) begin
            chk("status_queue_empty", 1, 0);
        end else begin
            s = tq.pop_front();
            chk("grant_valid", int'(grant_valid), int'(s.gv));
            chk("burst_cnt", int'(burst_cnt), s.bc);
            chk("idle", int'(idle), int'(s.idl));
            if (s.gv || s.rst) chk("grant", int'(grant), s.grant);
        end
        if (rx_rden != '0) begin
            ridx = 0;
            for (int i = 0; i < N; i++) if (rx_rden[i]) ridx = i;
            if (sq.size() == 0) begin
                chk("unexpected_strobe_idx", ridx, -1);
            end else begin
                e = sq.pop_front();
                chk("strobe_idx", ridx, e.idx);
                chk("strobe_burst_pos", int'(burst_cnt), e.bc);
            end
        end else if (sq.size() != 0) begin
            e = sq.pop_front();
            chk("missing_strobe_idx", -1, e.idx);
        end
        if (grant_valid && !prev_gv) gseq.push_back(int'(grant));
        prev_gv = grant_valid;
    end

    // One clock of FIFO emulation: words strobed this cycle leave the FIFOs.
    task automatic cyc();
        logic [N-1:0] pend;
        @(negedge clk);
        pend = rx_rden;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (pend[i] && cnt[i] > 0) cnt[i]--;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        rx_almost_full = '0;
        out_full = 1'b0;
        run(4);
    endtask

    task automatic pulse_reset();
        rst_l = 1'b0;
        run(1);
        rst_l = 1'b1;
    endtask

    initial begin
        rst_l = 1'b0; en = 1'b0; out_full = 1'b0; rx_almost_full = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        run(3);
        rst_l = 1'b1;
        run(2);

        // Single requester: periph 3 with 5 words.
        en = 1'b1;
        cnt[3] = 5;
        run(20);
        chk("single_drained", cnt[3], 0);

        // Round robin from a fresh reset: order 0..7 then 0.
        pulse_reset();
        gseq.delete();
        for (int i = 0; i < N; i++) cnt[i] = 8;
        run(56);
        for (int k = 0; k < 9; k++) chk("rr_order", (gseq.size() > k) ? gseq[k] : -1, k % N);
        clear_all();

        // Urgency preempts periph 2 mid-burst.
        pulse_reset();
        gseq.delete();
        cnt[2] = 8;
        run(3);
        for (int i = 3; i <= 6; i++) cnt[i] = 8;
        rx_almost_full[6] = 1'b1;
        run(10);
        chk("urgent_first", (gseq.size() > 0) ? gseq[0] : -1, 2);
        chk("urgent_second", (gseq.size() > 1) ? gseq[1] : -1, 6);
        clear_all();

        // Backpressure mid-burst.
        cnt[1] = 20;
        run(3);
        out_full = 1'b1;
        run(10);
        out_full = 1'b0;
        run(10);
        clear_all();

        // Enable drop mid-burst, requests kept pending.
        cnt[5] = 20;
        run(3);
        en = 1'b0;
        cnt[0] = 6;
        run(8);
        en = 1'b1;
        run(6);
        clear_all();

        // Reset mid-burst, then round robin restarts at 0.
        cnt[4] = 20;
        run(3);
        rst_l = 1'b0;
        run(2);
        rst_l = 1'b1;
        gseq.delete();
        for (int i = 0; i < N; i++) cnt[i] = 8;
        run(8);
        chk("rr_restart", (gseq.size() > 0) ? gseq[0] : -1, 0);
        clear_all();

        // Randomized traffic.
        repeat (1500) begin
            en       = ($urandom_range(0, 15) != 0);
            out_full = ($urandom_range(0, 3) == 0);
            rst_l    = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                rx_almost_full[i] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 5) == 0) cnt[i] += $urandom_range(1, 6);
            end
            cyc();
        end
        rst_l = 1'b1;
        en = 1'b0;
        clear_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
